nes_joypad_reader: RTL
======================

Name: nes_joypad_reader

Overview:
- Initiator side of the NES controller serial interface: drives latch (joy_strobe) and clock (joy_clock) to a physical NES pad and shifts in the 8 button bits on joy_data.
- Publishes a parallel, active-high button byte in the same bit order as the joypad_bits vector consumed by the NES core: {right,left,down,up,start,select,b,a}, with bit0 = A.
- Sits in the system `clock` domain (~21.477 MHz). Its output is OR-ed with USB and on-board buttons ahead of the core's joypad emulation.

Parameters:
- C_tick_cycles, 128, system clocks per half-bit tick (128 = ~5.96 us at 21.477 MHz); legal range >= 4.
- C_poll_cycles, 357955, system clocks between automatic polls (~60 Hz); 0 disables auto-poll.

Ports:
- clock  in  1  system clock; all logic rises on this edge.
- reset  in  1  asynchronous reset, active-high.
- poll  in  1  one-cycle request to start a transaction.
- joy_data  in  1  serial data from the pad, active-low (0 = pressed); asynchronous to `clock`.
- joy_strobe  out  1  latch to the pad, active-high.
- joy_clock  out  1  shift clock to the pad; idles low; the pad shifts on the falling edge.
- buttons  out  8  last complete sample, 1 = pressed.
- valid  out  1  one-cycle pulse when `buttons` updates.
- busy  out  1  high while a transaction is in progress.

Behaviour:
- Reset:
  - Reset is asynchronous and active-high.
  - On reset, all outputs are 0, the FSM goes to IDLE, and the tick counter, poll timer, pending flag and shift register are cleared.
  - Asserting reset mid-transaction aborts it immediately; joy_strobe and joy_clock drop in the same instant.
- joy_data synchroniser:
  - joy_data passes through a 2-FF synchroniser (data_s).
  - Every sample uses data_s on the last cycle of a tick.
- Tick counter:
  - Counts 0..C_tick_cycles-1 while busy, then wraps to 0.
  - "tick end" means count == C_tick_cycles-1.
  - Held at 0 in IDLE.
- Poll timer:
  - Counts 0..C_poll_cycles-1 and sets `pending` on wrap.
  - A `poll` pulse also sets `pending`.
  - `pending` is cleared when a transaction starts.
  - A request arriving while busy is held in `pending`, not dropped; multiple requests collapse into one.
- FSM states and transitions:
  - IDLE: strobe=0, clk=0, busy=0. If pending, go to LATCH on the next cycle with busy=1 and bit index n=0.
  - LATCH: strobe=1 for 2 ticks, then go to GAP.
  - GAP: strobe=0 for 1 tick. At tick end sample bit0: shreg[0] = ~data_s. Then go to CLK_HI with n=1.
  - CLK_HI: joy_clock=1 for 1 tick, then go to CLK_LO.
  - CLK_LO: joy_clock=0 for 1 tick. At tick end: shreg[n] = ~data_s.
    - If n==7, go to DONE.
    - Otherwise n=n+1 and go to CLK_HI.
  - DONE: for one cycle, buttons <= shreg and valid=1; busy stays high. Next cycle go to IDLE.
- Timing of a transaction:
  - 17 ticks plus 2 cycles from leaving IDLE to `valid`: 2178 cycles at the default parameters.
  - Exactly 7 joy_clock high pulses, each C_tick_cycles long.
  - joy_strobe high for 2*C_tick_cycles.
- Update and outputs:
  - `buttons` updates atomically, only in DONE; partial or aborted transactions never reach it.
  - joy_strobe and joy_clock are registered outputs: glitch-free, and never high at the same time.
- Simultaneous events:
  - A poll pulse and a timer wrap in the same cycle produce one pending request.
  - A poll pulse in the DONE cycle starts a new transaction right after IDLE (IDLE lasts 1 cycle).
- Unplugged pad: the data line is pulled high, so the result is buttons=8'h00, with valid still pulsing normally.

Test Plan:
- Reset: hold reset, release, C_poll_cycles=0 -> all outputs 0, no strobe activity for 10000 cycles.
- Single poll, pad model returns bit stream A..right as active-low 0,1,1,0,1,1,1,0 (A and up and right pressed, i.e. buttons 8'b10001001) -> strobe high 256 cycles, 7 clock pulses of 128 cycles, valid pulse 2178 cycles after the poll registers, buttons=8'h89.
- Auto-poll, C_poll_cycles=5000, C_tick_cycles=8, pad model all released (joy_data=1) -> a transaction starts every 5000 cycles, each ends with valid and buttons=8'h00.
- Poll asserted 3 times mid-transaction -> exactly one follow-on transaction after DONE, then IDLE.
- Reset asserted during CLK_HI of bit 4 while buttons=8'h89 -> joy_clock=0 and joy_strobe=0 immediately, buttons=8'h00, busy=0. The next poll yields a correct full transaction.
- Pad model changes data on joy_clock falling edges with random 0-3 cycle skew, 100 random patterns -> buttons always equal the inverted sent pattern, and valid pulses exactly once per transaction.

Source files
------------

// File: rtl/nes_joypad_reader.sv
// nes_joypad_reader
//   Initiator side of the NES controller serial link. Latches the pad with
//   joy_strobe, clocks the remaining bits out with joy_clock and publishes
//   the 8 buttons as a parallel, active-high byte
//   {right,left,down,up,start,select,b,a}. Bit 0 is A.
//
// Ports
//   clock      in   system clock, all logic on the rising edge
//   reset      in   asynchronous reset, active-high
//   poll       in   one-cycle request to start a transaction
//   joy_data   in   serial data from the pad, active-low, asynchronous
//   joy_strobe out  latch to the pad, active-high, registered
//   joy_clock  out  shift clock to the pad, idles low, registered
//   buttons    out  last complete sample, 1 = pressed
//   valid      out  one-cycle pulse together with each buttons update
//   busy       out  high while a transaction is in progress
module nes_joypad_reader #(
  parameter int C_tick_cycles = 128,
  parameter int C_poll_cycles = 357955
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       poll,
  input  logic       joy_data,
  output logic       joy_strobe,
  output logic       joy_clock,
  output logic [7:0] buttons,
  output logic       valid,
  output logic       busy
);

  localparam int TW = (C_tick_cycles > 1) ? $clog2(C_tick_cycles) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(C_tick_cycles - 1);
  localparam bit POLL_EN = (C_poll_cycles > 0);
  localparam int PW = (C_poll_cycles > 1) ? $clog2(C_poll_cycles) : 1;
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_EN ? C_poll_cycles - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_GAP,
    S_CLK_HI,
    S_CLK_LO,
    S_DONE
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [TW-1:0] tick_cnt;
  logic          tick_end;
  logic [2:0]    bit_idx;
  logic [2:0]    bit_idx_next;
  logic          sample_en;
  logic          start;
  logic [7:0]    shreg;
  logic          data_meta;
  logic          data_s;
  logic [PW-1:0] poll_cnt;
  logic          poll_wrap;
  logic          pending;

  assign tick_end  = (tick_cnt == TICK_LAST);
  assign poll_wrap = POLL_EN && (poll_cnt == POLL_LAST);
  assign start     = (state == S_IDLE) && pending;
  assign busy      = (state != S_IDLE);

  // Two-flop synchroniser for the pad data line.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_meta <= 1'b1;
      data_s    <= 1'b1;
    end else begin
      data_meta <= joy_data;
      data_s    <= data_meta;
    end
  end

  // Free-running auto-poll timer; it keeps counting during transactions so
  // the poll rate stays exact.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      poll_cnt <= '0;
    end else if (!POLL_EN || poll_wrap) begin
      poll_cnt <= '0;
    end else begin
      poll_cnt <= poll_cnt + 1'b1;
    end
  end

  // Request flag. Requests collapse into one; a request landing in the very
  // cycle a transaction starts is kept for the next one.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pending <= 1'b0;
    end else if (start) begin
      pending <= poll | poll_wrap;
    end else begin
      pending <= pending | poll | poll_wrap;
    end
  end

  // Half-bit tick counter, parked at 0 whenever no tick is being timed.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tick_cnt <= '0;
    end else if (state == S_IDLE || state == S_DONE || tick_end) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  // Next-state logic. bit_idx doubles as the tick counter inside LATCH and
  // as the bit number during the clocked phase.
  always_comb begin
    state_next   = state;
    bit_idx_next = bit_idx;
    sample_en    = 1'b0;
    case (state)
      S_IDLE: begin
        if (pending) begin
          state_next   = S_LATCH;
          bit_idx_next = 3'd0;
        end
      end
      S_LATCH: begin
        if (tick_end) begin
          if (bit_idx == 3'd1) begin
            state_next   = S_GAP;
            bit_idx_next = 3'd0;
          end else begin
            bit_idx_next = bit_idx + 3'd1;
          end
        end
      end
      S_GAP: begin
        if (tick_end) begin
          sample_en    = 1'b1;
          state_next   = S_CLK_HI;
          bit_idx_next = 3'd1;
        end
      end
      S_CLK_HI: begin
        if (tick_end) begin
          state_next = S_CLK_LO;
        end
      end
      S_CLK_LO: begin
        if (tick_end) begin
          sample_en = 1'b1;
          if (bit_idx == 3'd7) begin
            state_next = S_DONE;
          end else begin
            bit_idx_next = bit_idx + 3'd1;
            state_next   = S_CLK_HI;
          end
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // State, sample capture and registered pad/host outputs. Strobe and clock
  // are decoded from the next state so they line up exactly with the state
  // they belong to and can never overlap.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      bit_idx    <= 3'd0;
      shreg      <= 8'h00;
      joy_strobe <= 1'b0;
      joy_clock  <= 1'b0;
      buttons    <= 8'h00;
      valid      <= 1'b0;
    end else begin
      state      <= state_next;
      bit_idx    <= bit_idx_next;
      joy_strobe <= (state_next == S_LATCH);
      joy_clock  <= (state_next == S_CLK_HI);
      valid      <= (state == S_DONE);
      if (sample_en) begin
        shreg[bit_idx] <= ~data_s;
      end
      if (state == S_DONE) begin
        buttons <= shreg;
      end
    end
  end

endmodule
